// File: rtl/bus_arbiter_pkg.sv
// Shared types and default constants for the CPU/DMA bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_HANDOFF = 2'd1,
        ST_DMA     = 2'd2,
        ST_RETURN  = 2'd3
    } arb_state_e;

    localparam int unsigned MAX_BURST_DEFAULT = 16;
    localparam int unsigned CPU_MIN_DEFAULT   = 4;
    localparam int unsigned CNT_W             = 8;

endpackage

// File: rtl/bus_arbiter.sv
// Shares one memory bus between a CPU and a DMA engine: bounded DMA bursts,
// one-cycle handoff/return gaps and a guaranteed CPU window between bursts.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT,
    parameter int unsigned CPU_MIN   = CPU_MIN_DEFAULT
) (
    input  logic        clk,
    input  logic        RST_N,
    input  logic [15:0] cpu_AD,
    input  logic [7:0]  cpu_DO,
    input  logic        cpu_WE,
    input  logic        dma_req,
    input  logic [15:0] dma_AD,
    input  logic [7:0]  dma_DO,
    input  logic        dma_WE,
    output logic        RDY,
    output logic        dma_gnt,
    output logic [15:0] mem_AD,
    output logic [7:0]  mem_DO,
    output logic        mem_WE
);

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(CPU_MIN);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0] cool_q,  cool_d;

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_CPU;
            burst_q <= '0;
            cool_q  <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            cool_q  <= cool_d;
        end
    end

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        cool_d  = cool_q;
        unique case (state_q)
            ST_CPU: begin
                if (cool_q != '0) begin
                    cool_d = cool_q - 1'b1;
                end
                // Cooldown expires in the cycle it decrements to zero, so a
                // reload of CPU_MIN grants exactly CPU_MIN CPU cycles (min one).
                if (dma_req && !cpu_WE && (cool_q <= CNT_W'(1))) begin
                    state_d = ST_HANDOFF;
                    burst_d = '0;
                end
            end
            ST_HANDOFF: begin
                state_d = ST_DMA;
                burst_d = '0;
            end
            ST_DMA: begin
                burst_d = burst_q + 1'b1;
                if (!dma_req || (burst_q == BURST_LAST)) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                state_d = ST_CPU;
                cool_d  = COOL_LOAD;
            end
            default: begin
                state_d = ST_CPU;
            end
        endcase
    end

    // Handshake outputs depend on the state flops alone.
    assign RDY     = (state_q == ST_CPU);
    assign dma_gnt = (state_q == ST_DMA);

    always_comb begin
        mem_AD = cpu_AD;
        mem_DO = cpu_DO;
        mem_WE = 1'b0;
        unique case (state_q)
            ST_CPU: begin
                mem_WE = cpu_WE;
            end
            ST_DMA: begin
                mem_AD = dma_AD;
                mem_DO = dma_DO;
                mem_WE = dma_WE;
            end
            default: begin
                mem_WE = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic
// compared against a cycle-counting reference model.
module tb_bus_arbiter;

    localparam int MB = 16;
    localparam int CM = 4;

    logic        clk = 1'b0;
    logic        RST_N;
    logic [15:0] cpu_AD;
    logic [7:0]  cpu_DO;
    logic        cpu_WE;
    logic        dma_req;
    logic [15:0] dma_AD;
    logic [7:0]  dma_DO;
    logic        dma_WE;
    logic        RDY;
    logic        dma_gnt;
    logic [15:0] mem_AD;
    logic [7:0]  mem_DO;
    logic        mem_WE;

    logic [26:0] obs;
    assign obs = {RDY, dma_gnt, mem_AD, mem_DO, mem_WE};

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_BURST(MB), .CPU_MIN(CM)) dut (
        .clk     (clk),
        .RST_N   (RST_N),
        .cpu_AD  (cpu_AD),
        .cpu_DO  (cpu_DO),
        .cpu_WE  (cpu_WE),
        .dma_req (dma_req),
        .dma_AD  (dma_AD),
        .dma_DO  (dma_DO),
        .dma_WE  (dma_WE),
        .RDY     (RDY),
        .dma_gnt (dma_gnt),
        .mem_AD  (mem_AD),
        .mem_DO  (mem_DO),
        .mem_WE  (mem_WE)
    );

    // Reference model: who owns the bus, how many DMA cycles this burst has
    // used, and how many CPU cycles have elapsed since the last burst ended.
    localparam int P_CPU = 0, P_HO = 1, P_DMA = 2, P_RET = 3;
    int          m_phase;
    int          m_used;
    int          m_cpu_run;
    logic [26:0] exp_vec;

    function automatic void model_reset();
        m_phase   = P_CPU;
        m_used    = 0;
        m_cpu_run = 1000;
    endfunction

    function automatic void model_step();
        if (!RST_N) begin
            model_reset();
        end else begin
            case (m_phase)
                P_CPU: begin
                    if (m_cpu_run < 1000) m_cpu_run++;
                    if (dma_req && !cpu_WE && m_cpu_run >= CM) m_phase = P_HO;
                end
                P_HO: begin
                    m_used  = 0;
                    m_phase = P_DMA;
                end
                P_DMA: begin
                    m_used++;
                    if (!dma_req || m_used == MB) m_phase = P_RET;
                end
                default: begin
                    m_cpu_run = 0;
                    m_phase   = P_CPU;
                end
            endcase
        end
    endfunction

    function automatic void model_expect();
        case (m_phase)
            P_CPU:   exp_vec = {1'b1, 1'b0, cpu_AD, cpu_DO, cpu_WE};
            P_DMA:   exp_vec = {1'b0, 1'b1, dma_AD, dma_DO, dma_WE};
            default: exp_vec = {1'b0, 1'b0, cpu_AD, cpu_DO, 1'b0};
        endcase
    endfunction

    // One clock cycle: advance the model past the edge just taken, drive new
    // inputs on the falling edge, then settle and form the expected outputs.
    task automatic tick(input logic rst, input logic req, input logic cwe,
                        input logic dwe, input logic fix_dma);
        @(negedge clk);
        model_step();
        RST_N   = rst;
        dma_req = req;
        cpu_WE  = cwe;
        dma_WE  = dwe;
        cpu_AD  = 16'($urandom);
        cpu_DO  = 8'($urandom);
        if (fix_dma) begin
            dma_AD = 16'h1234;
            dma_DO = 8'hA5;
        end else begin
            dma_AD = 16'($urandom);
            dma_DO = 8'($urandom);
        end
        #1;
        if (!RST_N) model_reset();
        model_expect();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            vectors++;
            if ({RDY, dma_gnt} !== 2'b10) begin
                miscompares++;
                $display("FAIL reset_rdy_gnt k=%0d got %b exp 10", k, {RDY, dma_gnt});
            end
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_vec k=%0d got %h exp %h", k, obs, exp_vec);
            end
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (mem_AD !== cpu_AD) begin
            miscompares++;
            $display("FAIL reset_release_ad got %h exp %h", mem_AD, cpu_AD);
        end
    endtask

    task automatic test_single_request();
        logic [6:0] rdy_pat;
        logic [6:0] gnt_pat;
        rdy_pat = 7'b1100001;
        gnt_pat = 7'b0001100;
        idle(8);
        for (int k = 0; k < 7; k++) begin
            tick(1'b1, (k < 3), 1'b0, 1'($urandom), 1'b0);
            vectors++;
            if ({RDY, dma_gnt} !== {rdy_pat[k], gnt_pat[k]}) begin
                miscompares++;
                $display("FAIL single_req k=%0d got rdy/gnt %b exp %b", k,
                         {RDY, dma_gnt}, {rdy_pat[k], gnt_pat[k]});
            end
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL single_req_vec k=%0d got %h exp %h", k, obs, exp_vec);
            end
        end
    endtask

    task automatic test_burst_limit();
        logic hist [60];
        int first, len, gap, k;
        idle(8);
        for (int c = 0; c < 60; c++) begin
            tick(1'b1, 1'b1, 1'b0, 1'($urandom), 1'b0);
            hist[c] = dma_gnt;
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL burst_vec c=%0d got %h exp %h", c, obs, exp_vec);
            end
        end
        first = 0;
        while (first < 60 && hist[first] !== 1'b1) first++;
        k = first; len = 0;
        while (k < 60 && hist[k] === 1'b1) begin len++; k++; end
        gap = 0;
        while (k < 60 && hist[k] !== 1'b1) begin gap++; k++; end
        vectors++;
        if (first != 2) begin
            miscompares++;
            $display("FAIL burst_first_grant got %0d exp 2", first);
        end
        vectors++;
        if (len != MB) begin
            miscompares++;
            $display("FAIL burst_length got %0d exp %0d", len, MB);
        end
        vectors++;
        if (gap != CM + 2) begin
            miscompares++;
            $display("FAIL burst_gap got %0d exp %0d", gap, CM + 2);
        end
    endtask

    task automatic test_write_defer();
        idle(8);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b1, (k < 3), 1'b0, 1'b0);
            vectors++;
            if ({RDY, dma_gnt} !== 2'b10) begin
                miscompares++;
                $display("FAIL defer_cpu k=%0d got %b exp 10", k, {RDY, dma_gnt});
            end
        end
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({RDY, dma_gnt, mem_WE} !== 3'b000) begin
            miscompares++;
            $display("FAIL defer_handoff got rdy/gnt/we %b exp 000", {RDY, dma_gnt, mem_WE});
        end
        vectors++;
        if (obs !== exp_vec) begin
            miscompares++;
            $display("FAIL defer_handoff_vec got %h exp %h", obs, exp_vec);
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL defer_tail_vec k=%0d got %h exp %h", k, obs, exp_vec);
            end
        end
    endtask

    task automatic test_mux();
        idle(8);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        vectors++;
        if ({dma_gnt, mem_AD, mem_DO, mem_WE} !== {1'b1, 16'h1234, 8'hA5, 1'b1}) begin
            miscompares++;
            $display("FAIL mux_dma got %b %h %h %b exp 1 1234 a5 1",
                     dma_gnt, mem_AD, mem_DO, mem_WE);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        vectors++;
        if ({RDY, dma_gnt, mem_WE, mem_AD} !== {3'b000, cpu_AD}) begin
            miscompares++;
            $display("FAIL mux_return got %b %b %b %h exp 0 0 0 %h",
                     RDY, dma_gnt, mem_WE, mem_AD, cpu_AD);
        end
    endtask

    task automatic test_simultaneous_exit();
        logic er, eg;
        idle(8);
        for (int k = 0; k < 27; k++) begin
            tick(1'b1, (k != 17), 1'b0, 1'($urandom), 1'b0);
            er = (k == 0) || (k >= 19 && k <= 22);
            eg = (k >= 2 && k <= 17) || (k >= 24);
            vectors++;
            if ({RDY, dma_gnt} !== {er, eg}) begin
                miscompares++;
                $display("FAIL simul_exit k=%0d got rdy/gnt %b exp %b", k,
                         {RDY, dma_gnt}, {er, eg});
            end
        end
        idle(2);
    endtask

    task automatic test_reset_mid_burst();
        idle(8);
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (dma_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_setup got gnt %b exp 1", dma_gnt);
        end
        #2;
        RST_N = 1'b0;
        #1;
        vectors++;
        if ({RDY, dma_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL midrst_async got %b exp 10", {RDY, dma_gnt});
        end
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({RDY, dma_gnt, mem_AD} !== {2'b10, cpu_AD}) begin
            miscompares++;
            $display("FAIL midrst_release got %b %b %h exp 1 0 %h",
                     RDY, dma_gnt, mem_AD, cpu_AD);
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL midrst_after_vec k=%0d got %h exp %h", k, obs, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        logic req_r;
        req_r = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(7) == 0) req_r = ~req_r;
            tick(($urandom_range(199) != 0), req_r, ($urandom_range(3) == 0),
                 1'($urandom), 1'b0);
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL random_vec c=%0d got %h exp %h", c, obs, exp_vec);
            end
        end
    endtask

    initial begin
        RST_N   = 1'b0;
        cpu_AD  = '0;
        cpu_DO  = '0;
        cpu_WE  = 1'b0;
        dma_req = 1'b0;
        dma_AD  = '0;
        dma_DO  = '0;
        dma_WE  = 1'b0;
        model_reset();
        test_reset();
        test_single_request();
        test_burst_limit();
        test_write_defer();
        test_mux();
        test_simultaneous_exit();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
